// File: rtl/chunked_addsub_seq_if.sv
// Operand/result bundle for the chunked add/subtract unit.
// The requester drives start/sub/A/B/Cin; the unit returns busy/done/S/Cout/V.
interface chunked_addsub_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             V;

  modport master (
    output start, sub, A, B, Cin,
    input  busy, done, S, Cout, V
  );

  modport slave (
    input  start, sub, A, B, Cin,
    output busy, done, S, Cout, V
  );
endinterface

// File: rtl/chunked_addsub_seq.sv
// Sequential add/subtract: one CHUNK-bit ripple slice per clock, carry held in a register.
// Start accepted in IDLE only; done pulses one cycle after the last slice; start while busy/done is ignored.
module chunked_addsub_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  chunked_addsub_seq_if.slave  bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             v_q, v_d;
  logic [IW-1:0]    idx_q, idx_d;

  logic [CHUNK-1:0] slice_a;
  logic [CHUNK-1:0] slice_b;
  logic [CHUNK:0]   slice_sum;
  logic             last_slice;

  assign slice_a    = opa_q[idx_q*CHUNK +: CHUNK];
  assign slice_b    = opb_q[idx_q*CHUNK +: CHUNK];
  assign slice_sum  = {1'b0, slice_a} + {1'b0, slice_b} + {{CHUNK{1'b0}}, carry_q};
  assign last_slice = (idx_q == IW'(NCHUNK - 1));

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    s_d     = s_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    v_d     = v_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          // Subtract as A + ~B + ~borrow so one adder slice serves both modes.
          opa_d   = bus.A;
          opb_d   = bus.sub ? ~bus.B : bus.B;
          carry_d = bus.sub ? ~bus.Cin : bus.Cin;
          idx_d   = '0;
          s_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d[idx_q*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
        carry_d = slice_sum[CHUNK];
        idx_d   = idx_q + 1'b1;
        if (last_slice) begin
          // Flags come straight off the top slice so they are valid alongside done.
          cout_d  = slice_sum[CHUNK];
          v_d     = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                    (slice_sum[CHUNK-1] != opa_q[WIDTH-1]);
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      v_q     <= v_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.S    = s_q;
  assign bus.Cout = cout_q;
  assign bus.V    = v_q;
endmodule

// File: tb/tb_chunked_addsub_seq.sv
// Scoreboard bench: three instances (16/4, 8/2, 8/8); issue pushes expectations, per-DUT monitors pop on done.
module tb_chunked_addsub_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  chunked_addsub_seq_if #(.WIDTH(16)) b16 ();
  chunked_addsub_seq_if #(.WIDTH(8))  b8 ();
  chunked_addsub_seq_if #(.WIDTH(8))  b1 ();

  chunked_addsub_seq #(.WIDTH(16), .CHUNK(4)) u16 (.clk(clk), .rst_n(rst_n), .bus(b16));
  chunked_addsub_seq #(.WIDTH(8),  .CHUNK(2)) u8  (.clk(clk), .rst_n(rst_n), .bus(b8));
  chunked_addsub_seq #(.WIDTH(8),  .CHUNK(8)) u1  (.clk(clk), .rst_n(rst_n), .bus(b1));

  // Expected {Cout, V, S zero-extended to 16} and accept-cycle stamps per instance.
  logic [17:0] eq[3][$];
  int          lq[3][$];
  bit          prev_done[3];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Independent integer reference: plain add/subtract, signed overflow from operand/result signs.
  function automatic logic [17:0] model(input int w, input bit sub, input bit cin,
                                        input logic [15:0] a, input logic [15:0] b);
    int          r;
    logic [15:0] s;
    bit          co, v, sa, sb, ss;
    if (sub) r = int'(a) - int'(b) - int'(cin);
    else     r = int'(a) + int'(b) + int'(cin);
    s  = 16'(r & ((1 << w) - 1));
    co = sub ? (r >= 0) : (((r >> w) & 1) == 1);
    sa = a[w-1];
    sb = b[w-1];
    ss = s[w-1];
    v  = sub ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
    return {co, v, s};
  endfunction

  task automatic on_done(input int which, input logic [17:0] got, input int req_lat);
    logic [17:0] e;
    int          acc;
    check($sformatf("dut%0d_done_one_cycle", which), prev_done[which], 0);
    check($sformatf("dut%0d_done_expected", which), eq[which].size() > 0, 1);
    if (eq[which].size() > 0) begin
      e   = eq[which].pop_front();
      acc = lq[which].pop_front();
      check($sformatf("dut%0d_result{cout,v,s}", which), got, e);
      // Cycle count with the start cycle numbered 1.
      check($sformatf("dut%0d_latency", which), cyc - acc + 2, req_lat);
    end
  endtask

  always @(negedge clk) begin
    if (b16.done) on_done(0, {b16.Cout, b16.V, b16.S}, 6);
    if (b8.done)  on_done(1, {b8.Cout, b8.V, 8'h00, b8.S}, 6);
    if (b1.done)  on_done(2, {b1.Cout, b1.V, 8'h00, b1.S}, 3);
    prev_done[0] = b16.done;
    prev_done[1] = b8.done;
    prev_done[2] = b1.done;
  end

  task automatic issue(input int which, input bit sub, input bit cin,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [17:0] exp, input bit push);
    bit idle;
    idle = 1'b0;
    for (int k = 0; k < 64 && !idle; k++) begin
      @(negedge clk);
      case (which)
        0:       idle = !b16.busy && !b16.done;
        1:       idle = !b8.busy && !b8.done;
        default: idle = !b1.busy && !b1.done;
      endcase
    end
    check($sformatf("dut%0d_idle_wait", which), idle, 1);
    case (which)
      0: begin b16.start = 1'b1; b16.sub = sub; b16.Cin = cin; b16.A = a;      b16.B = b;      end
      1: begin b8.start  = 1'b1; b8.sub  = sub; b8.Cin  = cin; b8.A  = a[7:0]; b8.B  = b[7:0]; end
      default: begin b1.start = 1'b1; b1.sub = sub; b1.Cin = cin; b1.A = a[7:0]; b1.B = b[7:0]; end
    endcase
    if (push) eq[which].push_back(exp);
    @(posedge clk);
    #1;
    if (push) lq[which].push_back(cyc);
    // Scramble inputs after acceptance; the in-flight operation must not see them.
    case (which)
      0: begin b16.start = 1'b0; b16.sub = ~sub; b16.Cin = ~cin; b16.A = ~a;      b16.B = ~b;      end
      1: begin b8.start  = 1'b0; b8.sub  = ~sub; b8.Cin  = ~cin; b8.A  = ~a[7:0]; b8.B  = ~b[7:0]; end
      default: begin b1.start = 1'b0; b1.sub = ~sub; b1.Cin = ~cin; b1.A = ~a[7:0]; b1.B = ~b[7:0]; end
    endcase
  endtask

  task automatic vec16(input bit sub, input bit cin, input logic [15:0] a, input logic [15:0] b,
                       input bit cout, input bit v, input logic [15:0] s);
    issue(0, sub, cin, a, b, {cout, v, s}, 1'b1);
  endtask

  logic [7:0] vals [11] = '{8'h00, 8'h01, 8'h02, 8'h55, 8'h7E, 8'h7F,
                            8'h80, 8'h81, 8'hAA, 8'hFE, 8'hFF};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    bit got_done;
    b16.start = 1'b0; b16.sub = 1'b0; b16.Cin = 1'b0; b16.A = '0; b16.B = '0;
    b8.start  = 1'b0; b8.sub  = 1'b0; b8.Cin  = 1'b0; b8.A  = '0; b8.B  = '0;
    b1.start  = 1'b0; b1.sub  = 1'b0; b1.Cin  = 1'b0; b1.A  = '0; b1.B  = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_busy", b16.busy, 0);
    check("reset_done", b16.done, 0);
    check("reset_S",    b16.S,    0);
    check("reset_Cout", b16.Cout, 0);
    check("reset_V",    b16.V,    0);

    //    sub cin A         B         Cout V  S
    vec16(0, 0, 16'hFFFF, 16'h0001, 1, 0, 16'h0000);
    vec16(1, 0, 16'h0005, 16'h0007, 0, 0, 16'hFFFE);
    vec16(1, 0, 16'h8000, 16'h0001, 1, 1, 16'h7FFF);
    vec16(0, 1, 16'h7FFF, 16'h0000, 0, 1, 16'h8000);
    vec16(0, 0, 16'h1234, 16'h4321, 0, 0, 16'h5555);
    vec16(1, 1, 16'h0000, 16'h0000, 0, 0, 16'hFFFF);
    vec16(0, 0, 16'h8000, 16'h8000, 1, 1, 16'h0000);
    vec16(1, 0, 16'h7FFF, 16'hFFFF, 0, 1, 16'h8000);
    vec16(0, 1, 16'hFFFF, 16'hFFFF, 1, 0, 16'hFFFF);
    vec16(1, 1, 16'hFFFF, 16'h0001, 1, 0, 16'hFFFD);

    // Second start mid-RUN and another in the done cycle: both must be ignored.
    vec16(0, 0, 16'h1111, 16'h2222, 0, 0, 16'h3333);
    @(posedge clk);
    @(negedge clk);
    b16.start = 1'b1; b16.A = 16'hAAAA; b16.B = 16'h5555; b16.sub = 1'b1;
    @(negedge clk);
    b16.start = 1'b0;
    got_done = 1'b0;
    for (int k = 0; k < 20 && !got_done; k++) begin
      @(negedge clk);
      got_done = b16.done;
    end
    check("done_seen_after_midrun_start", got_done, 1);
    b16.start = 1'b1; b16.A = 16'h0F00; b16.B = 16'h00F0;
    @(negedge clk);
    b16.start = 1'b0;

    // Reset during slice 2, then a clean operation.
    issue(0, 1'b0, 1'b0, 16'h0F0F, 16'h0101, 18'h0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrun_reset_busy", b16.busy, 0);
    check("midrun_reset_done", b16.done, 0);
    check("midrun_reset_S",    b16.S,    0);
    check("midrun_reset_Cout", b16.Cout, 0);
    check("midrun_reset_V",    b16.V,    0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    vec16(0, 0, 16'h0F0F, 16'h0101, 0, 0, 16'h1010);

    // Boundary-value sweep on the 8-bit instances against the integer model.
    for (int w = 1; w <= 2; w++)
      for (int s = 0; s < 2; s++)
        for (int c = 0; c < 2; c++)
          for (int i = 0; i < 11; i++)
            for (int j = 0; j < 11; j++)
              issue(w, s[0], c[0], {8'h00, vals[i]}, {8'h00, vals[j]},
                    model(8, s[0], c[0], {8'h00, vals[i]}, {8'h00, vals[j]}), 1'b1);

    for (int k = 0; k < 200 && (eq[0].size() + eq[1].size() + eq[2].size()) != 0; k++)
      @(negedge clk);
    repeat (10) @(negedge clk);
    check("dut0_drained", eq[0].size(), 0);
    check("dut1_drained", eq[1].size(), 0);
    check("dut2_drained", eq[2].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
